// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access controller: request sizes, fault codes,
// FSM states and the default physical window.
package mem_ctrl_pkg;

  localparam logic [31:0] DEFAULT_START_ADDRESS = 32'h8002_0000;
  localparam logic [31:0] DEFAULT_MEM_BYTES     = 32'h0010_0000;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'b00,
    FAULT_RANGE = 2'b01,
    FAULT_ALIGN = 2'b10,
    FAULT_SIZE  = 2'b11
  } fault_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FAULT   = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_RESP = 3'd3,
    ST_RMW_RD  = 3'd4,
    ST_RMW_WR  = 3'd5,
    ST_WR_DONE = 3'd6
  } state_e;

  // Widened to 33 bits so the range check sum never wraps.
  function automatic logic [32:0] access_bytes(input size_e size);
    case (size)
      SIZE_BYTE: return 33'd1;
      SIZE_HALF: return 33'd2;
      default:   return 33'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_block.sv
// Word-wide memory with a one-cycle synchronous read; addressed by a
// word-aligned byte address.
module mem_block #(
  parameter int unsigned WORDS = 262144
) (
  input  logic        clock,
  input  logic [31:0] address,
  input  logic        wren,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int unsigned AW = $clog2(WORDS);

  logic [31:0]   mem_array [WORDS];
  logic [AW-1:0] index;
  logic          unused_address_bits;

  assign index               = address[AW+1:2];
  assign unused_address_bits = ^{address[31:AW+2], address[1:0]};

  always_ff @(posedge clock) begin
    if (wren) begin
      mem_array[index] <= wdata;
    end
    rdata <= mem_array[index];
  end

endmodule

// File: rtl/mem_lane_unit.sv
// Big-endian byte-lane logic: extracts and extends sub-word loads and merges
// sub-word store data into a read word.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];

    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:   load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged[31:24] = store_data[7:0];
          2'd1:    merged[23:16] = store_data[7:0];
          2'd2:    merged[15:8]  = store_data[7:0];
          default: merged[7:0]   = store_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) begin
          merged[15:0] = store_data[15:0];
        end else begin
          merged[31:16] = store_data[15:0];
        end
      end
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// CPU-side memory controller: logical-to-physical translation, range/alignment
// checking and byte/halfword/word accesses with read-modify-write sub-word stores.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS  = DEFAULT_START_ADDRESS,
  parameter logic [31:0] MEM_BYTES      = DEFAULT_MEM_BYTES,
  parameter bit          ENABLE_SUBWORD = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [1:0]  req_size,
  input  logic        req_sign_ext,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_code
);

  state_e      state_q, state_d;
  logic        wren_q, wren_d;
  size_e       size_q, size_d;
  logic        sign_ext_q, sign_ext_d;
  logic [31:0] pa_q, pa_d;
  logic [31:0] data_q, data_d;
  fault_e      fault_q, fault_d;

  size_e       size_in;
  logic [31:0] pa_in;
  logic [32:0] end_in;
  fault_e      fault_in;

  logic [31:0] mem_address;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign size_in = size_e'(req_size);
  assign pa_in   = req_address - START_ADDRESS;
  assign end_in  = {1'b0, pa_in} + access_bytes(size_in);

  // Checked in priority order so only the most important fault is reported.
  always_comb begin
    fault_in = FAULT_NONE;
    if (size_in == SIZE_RSVD || (!ENABLE_SUBWORD && size_in != SIZE_WORD)) begin
      fault_in = FAULT_SIZE;
    end else if (req_address < START_ADDRESS || end_in > {1'b0, MEM_BYTES}) begin
      fault_in = FAULT_RANGE;
    end else if ((size_in == SIZE_HALF && pa_in[0]) ||
                 (size_in == SIZE_WORD && pa_in[1:0] != 2'b00)) begin
      fault_in = FAULT_ALIGN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wren_q     <= 1'b0;
      size_q     <= SIZE_WORD;
      sign_ext_q <= 1'b0;
      pa_q       <= '0;
      data_q     <= '0;
      fault_q    <= FAULT_NONE;
    end else begin
      state_q    <= state_d;
      wren_q     <= wren_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      pa_q       <= pa_d;
      data_q     <= data_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wren_d     = wren_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    pa_d       = pa_q;
    data_d     = data_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wren_d     = req_wren;
          size_d     = size_in;
          sign_ext_d = req_sign_ext;
          pa_d       = pa_in;
          data_d     = req_data;
          fault_d    = fault_in;
          if (fault_in != FAULT_NONE) begin
            state_d = ST_FAULT;
          end else if (!req_wren) begin
            state_d = ST_RD;
          end else if (size_in == SIZE_WORD) begin
            state_d = ST_WR_DONE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD:      state_d = ST_RD_RESP;
      ST_RMW_RD:  state_d = ST_RMW_WR;
      ST_RMW_WR:  state_d = ST_WR_DONE;
      ST_FAULT,
      ST_RD_RESP,
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Responses and writes are masked while reset is asserted so an aborted access leaves no trace.
  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    resp_valid      = 1'b0;
    resp_fault      = 1'b0;
    resp_fault_code = FAULT_NONE;
    resp_data       = '0;
    mem_wren        = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FAULT: begin
          resp_valid      = 1'b1;
          resp_fault      = 1'b1;
          resp_fault_code = fault_q;
        end
        ST_RD_RESP: begin
          resp_valid = 1'b1;
          resp_data  = load_data;
        end
        ST_RMW_WR: mem_wren = 1'b1;
        ST_WR_DONE: begin
          resp_valid = 1'b1;
          mem_wren   = wren_q && (size_q == SIZE_WORD);
        end
        default: ;
      endcase
    end
  end

  assign mem_address = {pa_q[31:2], 2'b00};
  assign mem_wdata   = (size_q == SIZE_WORD) ? data_q : merged;

  mem_lane_unit u_lane (
    .word       (mem_rdata),
    .offset     (pa_q[1:0]),
    .size       (size_q),
    .sign_ext   (sign_ext_q),
    .store_data (data_q),
    .load_data  (load_data),
    .merged     (merged)
  );

  mem_block #(
    .WORDS (MEM_BYTES / 32'd4)
  ) u_mem (
    .clock   (clock),
    .address (mem_address),
    .wren    (mem_wren),
    .wdata   (mem_wdata),
    .rdata   (mem_rdata)
  );

endmodule
